// File: rtl/seq_detect_ctrl.sv
`timescale 1ns/1ps
// Scan controller: streams a latched 16-bit word MSB-first into an external
// 1100 Moore detector and tallies the detections it reports back.
module seq_detect_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [15:0] data_in,
  input  logic        abort,
  output logic        det_bit,
  output logic        det_rst,
  input  logic        det_z,
  output logic        busy,
  output logic        done,
  output logic [2:0]  hit_count,
  output logic        hit_any,
  output logic [3:0]  first_hit_idx
);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] sreg_q, sreg_d;
  logic [3:0]  k_q, k_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  res_cnt_q, res_cnt_d;
  logic [3:0]  res_idx_q, res_idx_d;
  logic        live_q;
  logic        accept, attrib;
  logic [3:0]  attr_idx;

  // live_q keeps start_ready low and det_rst high until the first edge after reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      res_cnt_q <= '0;
      res_idx_q <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      res_cnt_q <= res_cnt_d;
      res_idx_q <= res_idx_d;
      live_q    <= 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    res_cnt_d   = res_cnt_q;
    res_idx_d   = res_idx_q;
    start_ready = live_q && (state_q == IDLE);
    det_rst     = !live_q;
    det_bit     = 1'b0;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    accept      = start_valid && start_ready;

    // The detector answers one cycle late: det_z in SHIFT k belongs to bit k-1.
    attrib   = det_z && (((state_q == SHIFT) && (k_q != 4'd0)) || (state_q == DRAIN));
    attr_idx = (state_q == DRAIN) ? 4'd15 : k_q - 4'd1;
    if (attrib && (cnt_q != 3'd4)) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd0) idx_d = attr_idx;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d    = data_in;
          k_d       = '0;
          cnt_d     = '0;
          idx_d     = '0;
          res_cnt_d = '0;
          res_idx_d = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        det_rst = 1'b1;
        k_d     = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        det_bit = sreg_q[15];
        sreg_d  = {sreg_q[14:0], 1'b0};
        k_d     = k_q + 4'd1;
        if (k_q == 4'd15) state_d = DRAIN;
      end
      DRAIN: begin
        res_cnt_d = cnt_d;
        res_idx_d = idx_d;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort && busy && (state_q != DONE)) begin
      det_rst   = 1'b1;
      sreg_d    = '0;
      k_d       = '0;
      cnt_d     = '0;
      idx_d     = '0;
      res_cnt_d = '0;
      res_idx_d = '0;
      state_d   = IDLE;
    end
  end

  assign hit_count     = res_cnt_q;
  assign hit_any       = (res_cnt_q != 3'd0);
  assign first_hit_idx = res_idx_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for seq_detect_ctrl with a 1100 Moore detector
// model closing the det_bit -> det_z loop.
module tb_seq_detect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] data_in;
  logic        abort;
  logic        det_bit;
  logic        det_rst;
  logic        det_z;
  logic        busy;
  logic        done;
  logic [2:0]  hit_count;
  logic        hit_any;
  logic [3:0]  first_hit_idx;

  typedef struct {
    int cnt;
    int idx;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  seq_detect_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .data_in       (data_in),
    .abort         (abort),
    .det_bit       (det_bit),
    .det_rst       (det_rst),
    .det_z         (det_z),
    .busy          (busy),
    .done          (done),
    .hit_count     (hit_count),
    .hit_any       (hit_any),
    .first_hit_idx (first_hit_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External detector: z rises the cycle after the last bit of 1100 is clocked in.
  logic [3:0] det_hist = '0;
  logic       det_zq   = 1'b0;
  always @(posedge clk) begin
    if (det_rst) begin
      det_hist <= '0;
      det_zq   <= 1'b0;
    end else begin
      det_hist <= {det_hist[2:0], det_bit};
      det_zq   <= ({det_hist[2:0], det_bit} == 4'b1100);
    end
  end
  assign det_z = det_zq;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: slide a 4-bit window over the word, index 0 = MSB.
  function automatic void ref_scan(input logic [15:0] d, output int cnt, output int first);
    bit b [16];
    for (int i = 0; i < 16; i++) b[i] = d[15-i];
    cnt   = 0;
    first = 0;
    for (int i = 3; i < 16; i++) begin
      if (b[i-3] && b[i-2] && !b[i-1] && !b[i]) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.done_cyc);
        check("hit_count", int'(hit_count), mon_e.cnt);
        check("hit_any", int'(hit_any), (mon_e.cnt != 0) ? 1 : 0);
        check("first_hit_idx", int'(first_hit_idx), mon_e.idx);
        check("ready_in_done", int'(start_ready), 0);
        check("busy_in_done", int'(busy), 1);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_det_rst"}, int'(det_rst), 1);
    check({tag, "_det_bit"}, int'(det_bit), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_start_ready"}, int'(start_ready), 0);
    check({tag, "_hit_count"}, int'(hit_count), 0);
    check({tag, "_hit_any"}, int'(hit_any), 0);
    check({tag, "_first_idx"}, int'(first_hit_idx), 0);
  endtask

  // abort_j: cycles after the accepting edge at which abort is raised
  // (0 = CLEAR, 1..16 = SHIFT, 17 = DRAIN, 18 = DONE); negative for none.
  task automatic run_scan(input logic [15:0] d, input int abort_j, input bit abort_on_start);
    int   cnt, first, acc, n;
    exp_t e;
    @(negedge clk);
    data_in     = d;
    start_valid = 1'b1;
    abort       = abort_on_start;
    n = 0;
    while (!start_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) begin
      check("accept_timeout", 0, 1);
      start_valid = 1'b0;
      abort       = 1'b0;
      return;
    end
    acc = cyc + 1;
    ref_scan(d, cnt, first);
    if (abort_j < 0 || abort_j > 17) begin
      e.cnt      = cnt;
      e.idx      = first;
      e.done_cyc = acc + 18;
      sb.push_back(e);
    end
    @(negedge clk);
    start_valid = 1'b0;
    abort       = 1'b0;
    data_in     = 16'($urandom);
    check("ready_low_clear", int'(start_ready), 0);
    check("det_rst_clear", int'(det_rst), 1);
    if (abort_j >= 0) begin
      repeat (abort_j) @(negedge clk);
      abort = 1'b1;
      #1;
      if (abort_j <= 17) check("det_rst_on_abort", int'(det_rst), 1);
      @(negedge clk);
      abort = 1'b0;
      if (abort_j <= 17) begin
        check("abort_idle", int'(busy), 0);
        check("abort_ready", int'(start_ready), 1);
        check("abort_hit_count", int'(hit_count), 0);
        check("abort_hit_any", int'(hit_any), 0);
        check("abort_first_idx", int'(first_hit_idx), 0);
      end
      repeat (3) @(negedge clk);
    end else begin
      repeat (19) @(negedge clk);
      check("hold_hit_count", int'(hit_count), cnt);
      check("hold_first_idx", int'(first_hit_idx), first);
    end
  endtask

  task automatic hold_test();
    int   prev, acc, n, cnt, first;
    exp_t e;
    ref_scan(16'hCCCC, cnt, first);
    @(negedge clk);
    data_in     = 16'hCCCC;
    start_valid = 1'b1;
    prev        = -1;
    for (int s = 0; s < 3; s++) begin
      n = 0;
      while (!start_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!start_ready) begin
        check("hold_timeout", 0, 1);
        break;
      end
      acc        = cyc + 1;
      e.cnt      = cnt;
      e.idx      = first;
      e.done_cyc = acc + 18;
      sb.push_back(e);
      if (prev >= 0) check("accept_period", acc - prev, 20);
      prev = acc;
      @(negedge clk);
      check("hold_ready_low", int'(start_ready), 0);
    end
    start_valid = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic reset_mid_scan();
    int n;
    @(negedge clk);
    data_in     = 16'hCCCC;
    start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) check("rst_accept_timeout", 0, 1);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", int'(start_ready), 1);
    check("midrst_det_rst_after", int'(det_rst), 0);
  endtask

  initial begin
    reset       = 1'b0;
    start_valid = 1'b0;
    abort       = 1'b0;
    data_in     = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);
    check("por_ready_after", int'(start_ready), 1);
    check("por_det_rst_after", int'(det_rst), 0);

    run_scan(16'hCCCC, -1, 1'b0);
    run_scan(16'hF000, -1, 1'b0);
    run_scan(16'h3000, -1, 1'b0);
    run_scan(16'h0000, -1, 1'b0);
    run_scan(16'hFFFF, -1, 1'b0);
    run_scan(16'hCCCC, 9, 1'b0);
    run_scan(16'hCCCC, 17, 1'b0);
    run_scan(16'h0CC0, 18, 1'b0);
    run_scan(16'hF000, -1, 1'b1);
    hold_test();
    reset_mid_scan();
    run_scan(16'hCCCC, -1, 1'b0);

    for (int r = 0; r < 16; r++) begin
      logic [15:0] d;
      int          aj;
      d  = 16'($urandom);
      aj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : -1;
      run_scan(d, aj, $urandom_range(0, 4) == 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous active-low reset; 0 forces reset state immediately.
REQ-004 start_valid  input  1  request to scan data_in.
REQ-005 start_ready  output  1  high only in IDLE; a start is accepted on a rising edge where start_valid and start_ready are both 1.
REQ-006 data_in  input  16  word to scan, sampled only on the accepting edge.
REQ-007 abort  input  1  synchronous cancel of the scan in progress.
REQ-008 det_bit  output  1  serial bit driven to the 1100 Moore detector's P1 input.
REQ-009 det_rst  output  1  active-high reset to the detector.
REQ-010 det_z  input  1  Moore output of the detector; 1 for one cycle per completed 1100.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when the scan results are valid.
REQ-013 hit_count  output  3  number of 1100 detections in the last completed scan (0..4).
REQ-014 hit_any  output  1  high when hit_count is non-zero.
REQ-015 first_hit_idx  output  4  index (0 = MSB) of the bit that completed the first detection; 0 when hit_any is 0.

Function
REQ-016 The FSM SHALL have five states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
REQ-017 IDLE: start_ready=1, det_rst=0; on accept, latch data_in into a 16-bit shift register, zero the internal counters, go to CLEAR.
REQ-018 CLEAR: det_rst=1 for exactly one cycle, bit index k=0, go to SHIFT.
REQ-019 SHIFT: det_bit SHALL equal shift-register bit 15 (MSB first); shift left one bit per cycle; stay for exactly 16 cycles (k=0..15), then go to DRAIN.
REQ-020 det_z observed in SHIFT cycle k (k>=1) SHALL be attributed to bit k-1; det_z in DRAIN SHALL be attributed to bit 15; det_z in SHIFT cycle 0 SHALL be ignored.
REQ-021 On each attributed det_z=1, hit_count SHALL increment (no wrap, max 4); the first attributed hit SHALL load first_hit_idx.
REQ-022 DRAIN: det_bit=0, one cycle, go to DONE.
REQ-023 DONE: done=1 for one cycle, go to IDLE; start_ready SHALL be 0 in DONE.
REQ-024 Latency: accept at edge T -> CLEAR in cycle T+1, SHIFT cycles T+2..T+17, DRAIN T+18, done=1 in cycle T+19.
REQ-025 hit_count, hit_any and first_hit_idx SHALL hold from done until the next accepted start, then clear to 0 on that accepting edge.
REQ-026 abort=1 in CLEAR, SHIFT or DRAIN SHALL go to IDLE on the next edge, clear results to 0, and produce no done pulse; det_rst=1 during the abort cycle.
REQ-027 abort in IDLE or DONE SHALL be ignored; DONE still pulses done.
REQ-028 If abort and start_valid are both 1 in IDLE, the start SHALL be accepted.
REQ-029 det_bit SHALL be 0 in every state except SHIFT.

Reset
REQ-030 While reset=0: state=IDLE, det_rst=1, det_bit=0, busy=0, done=0, start_ready=0, hit_count=0, hit_any=0, first_hit_idx=0, shift register=0.
REQ-031 On the first edge after reset deasserts, start_ready SHALL be 1 and det_rst SHALL be 0.
REQ-032 Reset asserted mid-scan SHALL abandon the scan immediately with no done pulse.

Verification
REQ-033 data_in=16'hCCCC -> done at T+19, hit_count=4, hit_any=1, first_hit_idx=3.
REQ-034 data_in=16'hF000 -> hit_count=1, first_hit_idx=5; data_in=16'h3000 -> hit_count=1, first_hit_idx=5.
REQ-035 data_in=16'h0000, then 16'hFFFF -> each gives hit_count=0, hit_any=0, first_hit_idx=0.
REQ-036 Start 16'hCCCC, abort in SHIFT cycle 8 -> IDLE next cycle, no done, results 0, det_rst=1 in the abort cycle.
REQ-037 Hold start_valid=1 continuously -> exactly one accept per 20 cycles, start_ready=0 while busy and in DONE.
REQ-038 Assert reset=0 in SHIFT cycle 5 -> all outputs at reset values at once; a later 16'hCCCC scan gives hit_count=4.
